// File: rtl/hyper_ca_ddr_in_pkg.sv
// hyper_ca_ddr_in_pkg: shared CA bit positions, slice-select encoding and CA word type
package hyper_ca_ddr_in_pkg;
    localparam int CA_RW = 47;
    localparam int CA_AS = 46;
    localparam int CA_BT = 45;
    typedef enum logic [1:0] {CA_HI, CA_MID, CA_LO, CA_WDATA} ca_sel_e;
    typedef logic [47:0] ca_word_t;
endpackage

// File: rtl/hyper_ddr_capture.sv
// hyper_ddr_capture: captures DDR read bytes on both RWDS edges and resyncs the pair into clk270
//   clk270     : resync clock
//   rst_ni     : async active-low reset
//   rwds_i     : delayed, centre-aligned read strobe
//   dq_i       : DDR read data byte
//   rx_en_i    : transfer captured pair on this clk270 edge
//   rx_data_o  : resynchronised {high, low} word
//   rx_valid_o : one-cycle valid per enabled edge
module hyper_ddr_capture (
    input  logic        clk270,
    input  logic        rst_ni,
    input  logic        rwds_i,
    input  logic [7:0]  dq_i,
    input  logic        rx_en_i,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o
);
    logic [7:0] r_hi;
    logic [7:0] r_lo;
    always_ff @(posedge rwds_i or negedge rst_ni) begin
        if (!rst_ni) r_hi <= '0;
        else         r_hi <= dq_i;
    end
    always_ff @(negedge rwds_i or negedge rst_ni) begin
        if (!rst_ni) r_lo <= '0;
        else         r_lo <= dq_i;
    end
    // The PHY guarantees the falling strobe settles before clk270 samples, so no synchroniser
    always_ff @(posedge clk270 or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= rx_en_i;
            if (rx_en_i) rx_data_o <= {r_hi, r_lo};
        end
    end
endmodule

// File: rtl/hyper_ca_ddr_in.sv
// hyper_ca_ddr_in: builds the 48-bit HyperBus CA word, slices it for DDR output, captures read data
//   clk270/rst_ni    : clock and async active-low reset
//   ca_load_i        : latch rw_i, address_space_i, burst_type_i, address_i
//   cmd_addr_o       : full CA word from latched fields
//   ca_sel_i         : slice select (0 hi, 1 mid, 2 lo, 3 write data)
//   wr_data_i        : write data passed through when ca_sel_i = 3
//   ca_word_o        : selected 16-bit slice
//   rwds_i/dq_i      : DDR read strobe and data
//   rx_en_i          : transfer captured read pair
//   rx_data_o        : resynchronised read word
//   rx_valid_o       : single-cycle valid for rx_data_o
// Macro HYPER_CA_OUT_REG_EN: when defined ca_word_o is registered (one cycle latency)
module hyper_ca_ddr_in
    import hyper_ca_ddr_in_pkg::*;
(
    input  logic        clk270,
    input  logic        rst_ni,
    input  logic        ca_load_i,
    input  logic        rw_i,
    input  logic        address_space_i,
    input  logic        burst_type_i,
    input  logic [31:0] address_i,
    output logic [47:0] cmd_addr_o,
    input  logic [1:0]  ca_sel_i,
    input  logic [15:0] wr_data_i,
    output logic [15:0] ca_word_o,
    input  logic        rwds_i,
    input  logic [7:0]  dq_i,
    input  logic        rx_en_i,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o
);
    logic        r_rw;
    logic        r_as;
    logic        r_bt;
    logic [31:0] r_addr;
    ca_word_t    w_ca;
    ca_sel_e     w_sel;
    logic [15:0] w_slice;
    always_ff @(posedge clk270 or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rw   <= 1'b0;
            r_as   <= 1'b0;
            r_bt   <= 1'b0;
            r_addr <= '0;
        end else if (ca_load_i) begin
            r_rw   <= rw_i;
            r_as   <= address_space_i;
            r_bt   <= burst_type_i;
            r_addr <= address_i;
        end
    end
    // Halfword address split: upper bits in CA[44:16], low three bits in CA[2:0], gap reserved zero
    always_comb begin
        w_ca         = '0;
        w_ca[CA_RW]  = r_rw;
        w_ca[CA_AS]  = r_as;
        w_ca[CA_BT]  = r_bt;
        w_ca[44:16]  = r_addr[31:3];
        w_ca[2:0]    = r_addr[2:0];
    end
    assign cmd_addr_o = w_ca;
    assign w_sel      = ca_sel_e'(ca_sel_i);
    assign w_slice    = (w_sel == CA_HI)  ? w_ca[47:32] :
                        (w_sel == CA_MID) ? w_ca[31:16] :
                        (w_sel == CA_LO)  ? w_ca[15:0]  : wr_data_i;
`ifdef HYPER_CA_OUT_REG_EN
    logic [15:0] r_ca_word;
    always_ff @(posedge clk270 or negedge rst_ni) begin
        if (!rst_ni) r_ca_word <= '0;
        else         r_ca_word <= w_slice;
    end
    assign ca_word_o = r_ca_word;
`else
    assign ca_word_o = w_slice;
`endif
    hyper_ddr_capture u_capture (
        .clk270     (clk270),
        .rst_ni     (rst_ni),
        .rwds_i     (rwds_i),
        .dq_i       (dq_i),
        .rx_en_i    (rx_en_i),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o)
    );
endmodule

// File: tb/tb_hyper_ca_ddr_in.sv
// tb_hyper_ca_ddr_in: directed self-checking bench for hyper_ca_ddr_in
module tb_hyper_ca_ddr_in;
    logic        clk270;
    logic        rst_ni;
    logic        ca_load_i;
    logic        rw_i;
    logic        address_space_i;
    logic        burst_type_i;
    logic [31:0] address_i;
    logic [47:0] cmd_addr_o;
    logic [1:0]  ca_sel_i;
    logic [15:0] wr_data_i;
    logic [15:0] ca_word_o;
    logic        rwds_i;
    logic [7:0]  dq_i;
    logic        rx_en_i;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    int checks;
    int errors;

    hyper_ca_ddr_in dut (
        .clk270          (clk270),
        .rst_ni          (rst_ni),
        .ca_load_i       (ca_load_i),
        .rw_i            (rw_i),
        .address_space_i (address_space_i),
        .burst_type_i    (burst_type_i),
        .address_i       (address_i),
        .cmd_addr_o      (cmd_addr_o),
        .ca_sel_i        (ca_sel_i),
        .wr_data_i       (wr_data_i),
        .ca_word_o       (ca_word_o),
        .rwds_i          (rwds_i),
        .dq_i            (dq_i),
        .rx_en_i         (rx_en_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o)
    );

    initial clk270 = 1'b0;
    always #5 clk270 = ~clk270;

    // Loads CA fields on the next edge and returns #1 after it
    task automatic load_ca(input logic rw, input logic as_, input logic bt, input logic [31:0] a);
        @(negedge clk270);
        rw_i = rw; address_space_i = as_; burst_type_i = bt; address_i = a; ca_load_i = 1'b1;
        @(posedge clk270);
        #1 ca_load_i = 1'b0;
    endtask

    // One rwds pulse within the low half of clk270
    task automatic rwds_pair(input logic [7:0] hi, input logic [7:0] lo);
        dq_i = hi; #1 rwds_i = 1'b1;
        #1 dq_i = lo; #1 rwds_i = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (cmd_addr_o !== 48'h0) begin errors++; $display("FAIL rst_cmd_addr got %h exp %h", cmd_addr_o, 48'h0); end
        checks++; if (rx_data_o !== 16'h0) begin errors++; $display("FAIL rst_rx_data got %h exp %h", rx_data_o, 16'h0); end
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid_o); end
        checks++; if (ca_word_o !== 16'h0) begin errors++; $display("FAIL rst_ca_word got %h exp %h", ca_word_o, 16'h0); end
        @(negedge clk270);
        rst_ni = 1'b1;
    endtask

    task automatic check_slice(input logic [1:0] sel, input logic [15:0] wd, input logic [15:0] exp, input string name);
        @(negedge clk270);
        ca_sel_i = sel; wr_data_i = wd;
`ifdef HYPER_CA_OUT_REG_EN
        #1;
        checks++; if (ca_word_o === exp && exp !== 16'h0) begin errors++; $display("FAIL %s_early got %h exp previous value", name, ca_word_o); end
        @(posedge clk270);
`endif
        #1;
        checks++; if (ca_word_o !== exp) begin errors++; $display("FAIL %s got %h exp %h", name, ca_word_o, exp); end
    endtask

    task automatic test_ca_read;
        load_ca(1'b1, 1'b0, 1'b1, 32'h0000_1234);
        checks++; if (cmd_addr_o !== 48'hA000_0246_0004) begin errors++; $display("FAIL ca_read got %h exp %h", cmd_addr_o, 48'hA000_0246_0004); end
        check_slice(2'd0, 16'h0, 16'hA000, "slice_hi");
        check_slice(2'd1, 16'h0, 16'h0246, "slice_mid");
        check_slice(2'd2, 16'h0, 16'h0004, "slice_lo");
    endtask

    task automatic test_ca_hold;
        @(negedge clk270);
        rw_i = 1'b0; address_space_i = 1'b1; burst_type_i = 1'b0; address_i = 32'hFFFF_FFFF;
        @(posedge clk270);
        #1;
        checks++; if (cmd_addr_o !== 48'hA000_0246_0004) begin errors++; $display("FAIL ca_hold got %h exp %h", cmd_addr_o, 48'hA000_0246_0004); end
    endtask

    task automatic test_ca_write;
        load_ca(1'b0, 1'b1, 1'b1, 32'h0000_0800);
        checks++; if (cmd_addr_o !== 48'h6000_0100_0000) begin errors++; $display("FAIL ca_write got %h exp %h", cmd_addr_o, 48'h6000_0100_0000); end
        check_slice(2'd0, 16'h0, 16'h6000, "wr_slice_hi");
        check_slice(2'd3, 16'h5A5A, 16'h5A5A, "slice_wdata");
        check_slice(2'd2, 16'h5A5A, 16'h0000, "wr_slice_lo");
    endtask

    task automatic test_ddr_single;
        @(negedge clk270);
        rwds_pair(8'hAB, 8'hCD);
        rx_en_i = 1'b1;
        @(posedge clk270);
        #1;
        checks++; if (rx_data_o !== 16'hABCD) begin errors++; $display("FAIL ddr_data got %h exp %h", rx_data_o, 16'hABCD); end
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL ddr_valid got %b exp 1", rx_valid_o); end
        @(negedge clk270);
        rx_en_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk270);
            #1;
            checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL ddr_valid_after%0d got %b exp 0", i, rx_valid_o); end
        end
        checks++; if (rx_data_o !== 16'hABCD) begin errors++; $display("FAIL ddr_data_hold got %h exp %h", rx_data_o, 16'hABCD); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [4];
        words = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk270);
            rwds_pair(words[i][15:8], words[i][7:0]);
            rx_en_i = 1'b1;
            @(posedge clk270);
            #1;
            checks++; if (rx_data_o !== words[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, rx_data_o, words[i]); end
            checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b exp 1", i, rx_valid_o); end
        end
        @(negedge clk270);
        rx_en_i = 1'b0;
        @(posedge clk270);
        #1;
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_end got %b exp 0", rx_valid_o); end
    endtask

    task automatic test_reset_mid;
        load_ca(1'b1, 1'b1, 1'b1, 32'h0000_00FF);
        @(negedge clk270);
        rwds_pair(8'h55, 8'h66);
        rx_en_i = 1'b1;
        @(posedge clk270);
        #1;
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", rx_valid_o); end
        rwds_i = 1'b0;
        dq_i = 8'h77;
        #1 rwds_i = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rx_valid got %b exp 0", rx_valid_o); end
        checks++; if (rx_data_o !== 16'h0) begin errors++; $display("FAIL mid_rx_data got %h exp %h", rx_data_o, 16'h0); end
        checks++; if (cmd_addr_o !== 48'h0) begin errors++; $display("FAIL mid_cmd_addr got %h exp %h", cmd_addr_o, 48'h0); end
        rwds_i = 1'b0;
        @(negedge clk270);
        rst_ni = 1'b1;
        @(posedge clk270);
        #1;
        checks++; if (rx_data_o !== 16'h0000) begin errors++; $display("FAIL mid_discard got %h exp %h", rx_data_o, 16'h0000); end
        @(negedge clk270);
        rwds_pair(8'h11, 8'h22);
        @(posedge clk270);
        #1;
        checks++; if (rx_data_o !== 16'h1122) begin errors++; $display("FAIL mid_fresh got %h exp %h", rx_data_o, 16'h1122); end
        checks++; if (rx_valid_o !== 1'b1) begin errors++; $display("FAIL mid_fresh_valid got %b exp 1", rx_valid_o); end
        @(negedge clk270);
        rx_en_i = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_ni = 1'b0; ca_load_i = 1'b0; rw_i = 1'b0; address_space_i = 1'b0; burst_type_i = 1'b0;
        address_i = '0; ca_sel_i = 2'd0; wr_data_i = '0; rwds_i = 1'b0; dq_i = '0; rx_en_i = 1'b0;
        test_reset;
        test_ca_read;
        test_ca_hold;
        test_ca_write;
        test_ddr_single;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
